// File: rtl/store_buffer_pkg.sv
// Shared store-path definitions: store op codes, the ALE exception code, and the
// buffer entry layout.
package store_buffer_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned WADDR_W = ADDR_W - 2;

  localparam logic [1:0] RAM_ST_B = 2'b01;
  localparam logic [1:0] RAM_ST_H = 2'b10;
  localparam logic [1:0] RAM_ST_W = 2'b11;

  // Exception code raised for an address-alignment error
  localparam logic [5:0] ECODE_ALE = 6'h09;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  wstrb;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store-request, memory-drain and load-hazard signals of the store buffer.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic              st_valid;
  logic              st_ready;
  logic [1:0]        st_op;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ale;
  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [STRB_W-1:0] bus_wstrb;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_conflict;
  logic              empty;

  modport slave (
    input  st_valid, st_op, st_addr, st_data, bus_ready, ld_addr,
    output st_ready, st_ale, bus_valid, bus_addr, bus_wdata, bus_wstrb, ld_conflict, empty
  );

  modport master (
    output st_valid, st_op, st_addr, st_data, bus_ready, ld_addr,
    input  st_ready, st_ale, bus_valid, bus_addr, bus_wdata, bus_wstrb, ld_conflict, empty
  );

endinterface

// File: rtl/store_buffer_st_align.sv
// Store lane alignment: replicates data into byte lanes, builds write strobes and
// flags misaligned or invalid stores.
module store_buffer_st_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]        i_op,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_wdata_c,
  output logic [STRB_W-1:0] o_wstrb_c,
  output logic              o_ale_c
);

  always_comb begin
    o_wdata_c = '0;
    o_wstrb_c = '0;
    o_ale_c   = 1'b0;
    case (i_op)
      RAM_ST_B: begin
        o_wdata_c = {4{i_data[7:0]}};
        o_wstrb_c = 4'b0001 << i_off;
      end
      RAM_ST_H: begin
        o_wdata_c = {2{i_data[15:0]}};
        o_wstrb_c = i_off[1] ? 4'b1100 : 4'b0011;
        o_ale_c   = i_off[0];
      end
      RAM_ST_W: begin
        o_wdata_c = i_data;
        o_wstrb_c = 4'b1111;
        o_ale_c   = |i_off;
      end
      default: o_ale_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between MEM stage and data memory. Build option STORE_FWD_EN
// narrows the load hazard to matching word addresses instead of any pending store.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           cpu_clk,
  input  logic           cpu_rstn,
  store_buffer_if.slave  sb
);

  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  sb_entry_t         r_mem [DEPTH];

  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;
  logic              w_ale;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_conflict;
  sb_entry_t         w_head;

  store_buffer_st_align u_align (
    .i_op      (sb.st_op),
    .i_off     (sb.st_addr[1:0]),
    .i_data    (sb.st_data),
    .o_wdata_c (w_wdata),
    .o_wstrb_c (w_wstrb),
    .o_ale_c   (w_ale)
  );

  assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = sb.st_valid & ~w_full & ~w_ale;
  assign w_pop    = ~w_empty & sb.bus_ready;
  assign w_head   = r_mem[r_rptr];

  assign sb.st_ale      = sb.st_valid & w_ale;
  assign sb.st_ready    = ~w_full;
  assign sb.empty       = w_empty;
  assign sb.bus_valid   = ~w_empty;
  assign sb.bus_addr    = {w_head.waddr, 2'b00};
  assign sb.bus_wdata   = w_head.wdata;
  assign sb.bus_wstrb   = w_head.wstrb;
  assign sb.ld_conflict = w_conflict;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[PTR_W'(i)] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= '{waddr: sb.st_addr[ADDR_W-1:2], wdata: w_wdata, wstrb: w_wstrb};
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] w_off;
  logic [1:0]       w_unused_ld_lo;
  assign w_unused_ld_lo = sb.ld_addr[1:0];

  // Only occupied slots (distance from head below count) take part in the match
  always_comb begin
    w_conflict = 1'b0;
    w_off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off = PTR_W'(i) - r_rptr;
      if (({1'b0, w_off} < r_count) &&
          (r_mem[PTR_W'(i)].waddr == sb.ld_addr[ADDR_W-1:2]))
        w_conflict = 1'b1;
    end
  end
`else
  logic [ADDR_W-1:0] w_unused_ld;
  assign w_unused_ld = sb.ld_addr;
  assign w_conflict  = ~w_empty;
`endif

endmodule
